mult_share_ctrl: RTL and testbench

- Round-robin controller that shares one sequential 4x4 signed shift-add multiplier among NUM_REQ requesters.
- Latches the winner's operands and sequences the multiplier's start/done handshake (start high until done, then start low until done drops).
- Returns the 8-bit signed product to the winner with a one-cycle response pulse.
- Sits between the requesting datapath blocks and the single multiplier instance.

---
 rtl/mult_share_pkg.sv | 25 ++
 rtl/mult_rr_pick.sv | 40 ++++
 rtl/mult_share_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mult_share_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_pkg
// Purpose  : Shared types and constants for the multiplier-sharing controller.
// Revision : 1.0 - initial release
// ============================================================================
package mult_share_pkg;

  // Controller states, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Operand and product widths of the shared multiplier
  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  // Default watchdog limit per phase (only used when the watchdog is built in)
  localparam int DEFAULT_TIMEOUT_CYCLES = 32;

endpackage : mult_share_pkg
`default_nettype wire

// File: rtl/mult_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : mult_rr_pick
// Purpose  : Combinational round-robin picker. Finds the first set request
//            bit searching upward from ptr_i, wrapping at NUM_REQ.
// Revision : 1.0 - initial release
// ============================================================================
module mult_rr_pick
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters starting at the pointer; the first hit wins
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule : mult_rr_pick
`default_nettype wire

// File: rtl/mult_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_ctrl
// Purpose  : Round-robin controller sharing one sequential 4x4 signed
//            multiplier among NUM_REQ requesters. Latches the winner's
//            operands, runs the start/done handshake and returns the product
//            with a one-cycle response pulse.
// Options  : MULT_SHARE_TIMEOUT_EN - adds a per-phase watchdog that aborts a
//            stuck multiplier operation with resp_err=1.
// Revision : 1.0 - initial release
// ============================================================================
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [OP_W*NUM_REQ-1:0]   a_in,
  input  logic [OP_W*NUM_REQ-1:0]   b_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [PROD_W-1:0]         resp_product,
  output logic                      resp_err,
  output logic                      busy,
  output logic                      mul_start,
  output logic [OP_W-1:0]           mul_a,
  output logic [OP_W-1:0]           mul_b,
  input  logic [PROD_W-1:0]         mul_product,
  input  logic                      mul_done
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]    own_q, own_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [OP_W-1:0]     mul_a_q, mul_a_d;
  logic [OP_W-1:0]     mul_b_q, mul_b_d;
  logic [PROD_W-1:0]   prod_q, prod_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;

`ifdef MULT_SHARE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                w_expired;
  assign w_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  mult_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Next-state logic: grant, handshake with the multiplier, respond
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    prod_d  = prod_q;
`ifdef MULT_SHARE_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          own_d   = pick_idx;
          mul_a_d = a_in[pick_idx*OP_W +: OP_W];
          mul_b_d = b_in[pick_idx*OP_W +: OP_W];
          state_d = ISSUE;
`ifdef MULT_SHARE_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      ISSUE: begin
        if (mul_done) begin
          prod_d  = mul_product;
          state_d = DRAIN;
`ifdef MULT_SHARE_TIMEOUT_EN
          cnt_d   = '0;
        end else if (w_expired) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      DRAIN: begin
        if (!mul_done) begin
          state_d = RESP;
`ifdef MULT_SHARE_TIMEOUT_EN
          cnt_d   = '0;
        end else if (w_expired) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        gnt_d   = '0;
        ptr_d   = (own_q == IDX_W'(NUM_REQ - 1)) ? '0 : own_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      prod_q  <= prod_d;
    end
  end

`ifdef MULT_SHARE_TIMEOUT_EN
  // Watchdog counter and sticky error flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign resp_err = err_q;
`else
  // Without the watchdog the error flag can never rise (limit is never negative)
  assign resp_err = (TIMEOUT_CYCLES < 0);
`endif

  assign gnt          = gnt_q;
  assign resp_valid   = (state_q == RESP) ? gnt_q : '0;
  assign resp_product = prod_q;
  assign busy         = (state_q != IDLE);
  assign mul_start    = (state_q == ISSUE);
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;

endmodule : mult_share_ctrl
`default_nettype wire

// File: tb/tb_mult_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_ctrl
// Purpose  : Self-checking bench for mult_share_ctrl with a behavioural
//            sequential multiplier and a round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_share_ctrl;

  localparam int N = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req   = '0;
  logic [4*N-1:0]  a_in  = '0;
  logic [4*N-1:0]  b_in  = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    resp_valid;
  logic [7:0]      resp_product;
  logic            resp_err;
  logic            busy;
  logic            mul_start;
  logic [3:0]      mul_a;
  logic [3:0]      mul_b;
  logic [7:0]      mul_product;
  logic            mul_done;

  int checks   = 0;
  int failures = 0;
  int model_ptr = 0;
  int mul_lat   = 0;
  bit mul_stuck = 1'b0;

  mult_share_ctrl #(.NUM_REQ(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .a_in         (a_in),
    .b_in         (b_in),
    .gnt          (gnt),
    .resp_valid   (resp_valid),
    .resp_product (resp_product),
    .resp_err     (resp_err),
    .busy         (busy),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_product  (mul_product),
    .mul_done     (mul_done)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mul8(input logic [3:0] a, input logic [3:0] b);
    int pa, pb;
    pa = $signed(a);
    pb = $signed(b);
    return 8'(pa * pb);
  endfunction

  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  // Behavioural sequential multiplier with programmable latency
  logic       m_busy;
  int         m_cnt;
  logic [7:0] m_res;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mul_done <= 1'b0; mul_product <= '0; m_busy <= 1'b0; m_cnt <= 0; m_res <= '0;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        mul_done <= 1'b1; mul_product <= m_res; m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (mul_start && !mul_done && !mul_stuck) begin
      m_busy <= 1'b1; m_cnt <= mul_lat; m_res <= mul8(mul_a, mul_b);
    end else if (!mul_start) begin
      mul_done <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // One arbitration round against the model; returns what the DUT produced
  task automatic serve(input string nm, input bit scramble,
                       output logic [N-1:0] rv, output logic [7:0] pr);
    int exp_i;
    logic [3:0] ea, eb;
    logic [7:0] exp_p;
    bit got;
    exp_i = model_pick(req, model_ptr);
    ea    = a_in[exp_i*4 +: 4];
    eb    = b_in[exp_i*4 +: 4];
    exp_p = mul8(ea, eb);
    if (!mul_stuck && mul_lat < 10) mul_lat = $urandom_range(0, 4);
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (gnt != '0) begin got = 1'b1; break; end
    end
    chk($sformatf("%s grant_seen", nm), 32'(got), 32'd1);
    chk($sformatf("%s gnt", nm), 32'(gnt), 32'(1) << exp_i);
    chk($sformatf("%s mul_a/b", nm), {24'd0, mul_a, mul_b}, {24'd0, ea, eb});
    chk($sformatf("%s busy", nm), 32'(busy), 32'd1);
    if (scramble) begin
      a_in[exp_i*4 +: 4] = 4'($urandom);
      b_in[exp_i*4 +: 4] = 4'($urandom);
    end
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (resp_valid != '0) begin got = 1'b1; break; end
    end
    chk($sformatf("%s resp_seen", nm), 32'(got), 32'd1);
    rv = resp_valid;
    pr = resp_product;
    chk($sformatf("%s resp_valid", nm), 32'(resp_valid), 32'(1) << exp_i);
    chk($sformatf("%s product", nm), 32'(resp_product), 32'(exp_p));
    chk($sformatf("%s resp_err", nm), 32'(resp_err), 32'd0);
    model_ptr = (exp_i + 1) % N;
  endtask

  typedef struct {
    logic [N-1:0]   req;
    logic [4*N-1:0] a;
    logic [4*N-1:0] b;
    int             idx;
    logic [7:0]     prod;
  } vec_t;

  vec_t tbl[14];

  initial begin : main
    logic [N-1:0] rv;
    logic [7:0]   pr;
    logic [N-1:0] prev;
    int           st;
    bit           got;

    tbl[0]  = '{4'b0001, 16'h0003, 16'h0005, 0, 8'h0F};
    tbl[1]  = '{4'b0010, 16'h00D0, 16'h0050, 1, 8'hF1};
    tbl[2]  = '{4'b0010, 16'h0080, 16'h0080, 1, 8'h40};
    tbl[3]  = '{4'b1000, 16'h7000, 16'hF000, 3, 8'hF9};
    tbl[4]  = '{4'b0101, 16'h0C02, 16'h0603, 0, 8'h06};
    tbl[5]  = '{4'b0100, 16'h0C02, 16'h0603, 2, 8'hE8};
    tbl[6]  = '{4'b0001, 16'h0001, 16'h000F, 0, 8'hFF};
    tbl[7]  = '{4'b0111, 16'h0F21, 16'h0871, 1, 8'h0E};
    tbl[8]  = '{4'b0101, 16'h0F21, 16'h0871, 2, 8'h08};
    tbl[9]  = '{4'b0001, 16'h0F21, 16'h0871, 0, 8'h01};
    tbl[10] = '{4'b1111, 16'h7887, 16'h7788, 1, 8'h40};
    tbl[11] = '{4'b1101, 16'h7887, 16'h7788, 2, 8'hC8};
    tbl[12] = '{4'b1001, 16'h7887, 16'h7788, 3, 8'h31};
    tbl[13] = '{4'b0001, 16'h7887, 16'h7788, 0, 8'hC8};

    // Reset state
    repeat (2) @(negedge clock);
    chk("reset gnt", 32'(gnt), 32'd0);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset outputs", {16'd0, resp_product, mul_a, mul_b}, 32'd0);
    chk("reset flags", {29'd0, resp_err, busy, mul_start}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed table (operand values and orderings worked out by hand)
    for (int i = 0; i < 14; i++) begin
      req  = tbl[i].req;
      a_in = tbl[i].a;
      b_in = tbl[i].b;
      serve($sformatf("tbl%0d", i), 1'b0, rv, pr);
      chk($sformatf("tbl%0d owner", i), 32'(rv), 32'(1) << tbl[i].idx);
      chk($sformatf("tbl%0d value", i), 32'(pr), 32'(tbl[i].prod));
    end
    req = '0;
    repeat (3) @(negedge clock);
    chk("idle after table", 32'(busy), 32'd0);

    // Randomized traffic: pending requests persist, winner drops after service
    for (int n = 0; n < 60; n++) begin
      prev = req;
      req  = req | N'($urandom_range(0, (1 << N) - 1));
      if (req == '0) req = N'(1) << $urandom_range(0, N - 1);
      for (int k = 0; k < N; k++) begin
        if (req[k] && !prev[k]) begin
          a_in[k*4 +: 4] = 4'($urandom);
          b_in[k*4 +: 4] = 4'($urandom);
        end
      end
      serve($sformatf("rnd%0d", n), n[0], rv, pr);
      req = req & ~rv;
    end
    req = '0;
    repeat (3) @(negedge clock);

    // Operand change after grant has no effect
    a_in[8 +: 4] = 4'd2;
    b_in[8 +: 4] = 4'd3;
    req = 4'b0100;
    mul_lat = 3;
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (gnt != '0) begin got = 1'b1; break; end
    end
    chk("opchg grant_seen", 32'(got), 32'd1);
    a_in[8 +: 4] = 4'd7;
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (mul_start) chk("opchg mul_a stable", 32'(mul_a), 32'd2);
      if (resp_valid != '0) begin got = 1'b1; break; end
      @(negedge clock);
    end
    chk("opchg resp_seen", 32'(got), 32'd1);
    chk("opchg product", 32'(resp_product), 32'h06);
    model_ptr = 3;
    req = '0;
    repeat (2) @(negedge clock);

    // Reset in the middle of ISSUE
    a_in[4 +: 4] = 4'd5;
    b_in[4 +: 4] = 4'd5;
    mul_lat = 20;
    req = 4'b0010;
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (mul_start) begin got = 1'b1; break; end
    end
    chk("rst issue_seen", 32'(got), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst mul_start", 32'(mul_start), 32'd0);
    chk("rst gnt", 32'(gnt), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_ptr = 0;
    mul_lat = 1;
    serve("post_reset", 1'b0, rv, pr);
    chk("post_reset value", 32'(pr), 32'h19);
    req = '0;
    repeat (2) @(negedge clock);

`ifdef MULT_SHARE_TIMEOUT_EN
    // Watchdog: multiplier never answers
    mul_stuck = 1'b1;
    a_in[3:0] = 4'd3;
    b_in[3:0] = 4'd5;
    req = 4'b0001;
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (gnt != '0) begin got = 1'b1; break; end
    end
    chk("tmo grant_seen", 32'(got), 32'd1);
    st  = mul_start ? 1 : 0;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (resp_valid != '0) begin got = 1'b1; break; end
      if (mul_start) st++;
    end
    chk("tmo resp_seen", 32'(got), 32'd1);
    chk("tmo start_cycles", 32'(st), 32'd32);
    chk("tmo resp_valid", 32'(resp_valid), 32'd1);
    chk("tmo resp_err", 32'(resp_err), 32'd1);
    chk("tmo product", 32'(resp_product), 32'h00);
    model_ptr = 1;
    mul_stuck = 1'b0;
    req = '0;
    repeat (2) @(negedge clock);
    req = 4'b0001;
    serve("tmo_recover", 1'b0, rv, pr);
    chk("tmo_recover value", 32'(pr), 32'h0F);
    req = '0;
    repeat (2) @(negedge clock);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mult_share_ctrl
`default_nettype wire
